block_plotter: RTL and testbench

//  Consumer side of the arrow-cell draw interface. Takes one (x,y,colour) cell request and plots it on
//  the VGA adapter. The request carries the top-left corner of a SIZE x SIZE square. The block emits
//  one pixel write per clock in raster order and pulses done when the square is finished.
//  It sits between the game/arrow FSMs and vga_adapter (160x120, 3-bit colour).

---
 rtl/block_plotter.sv | 99 +++++++++
 tb/tb_block_plotter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/block_plotter.sv
// Plots one SIZE x SIZE colour square on the VGA adapter, one pixel per clock in raster order.
// Pixels that fall off the visible screen keep their cycle but are not written.
//
// state | meaning
// IDLE  | waiting for a cell request, req_ready high
// DRAW  | scanning the square, one pixel per cycle
// DONE  | square finished, done pulses for one cycle
module block_plotter #(
  parameter int SIZE     = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [X_W-1:0] req_x,
  input  logic [Y_W-1:0] req_y,
  input  logic [C_W-1:0] req_color,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot,
  output logic           busy,
  output logic           done
);

  localparam int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t         state, state_nxt;
  logic [X_W-1:0] base_x;
  logic [Y_W-1:0] base_y;
  logic [C_W-1:0] base_c;
  logic [CNT_W-1:0] cx, cy;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;
  logic           last_px;

  assign last_px = (cx == LAST) && (cy == LAST);

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = DRAW;
      DRAW:    if (last_px)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters stop on the last pixel so the outputs keep showing it after DRAW.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      base_x <= '0;
      base_y <= '0;
      base_c <= '0;
      cx     <= '0;
      cy     <= '0;
    end else if (state == IDLE && req_valid) begin
      base_x <= req_x;
      base_y <= req_y;
      base_c <= req_color;
      cx     <= '0;
      cy     <= '0;
    end else if (state == DRAW && !last_px) begin
      if (cx == LAST) begin
        cx <= '0;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  // One extra bit keeps right/bottom overflow from wrapping back onto the screen.
  assign sum_x = {1'b0, base_x} + (X_W+1)'(cx);
  assign sum_y = {1'b0, base_y} + (Y_W+1)'(cy);

  assign vga_x      = sum_x[X_W-1:0];
  assign vga_y      = sum_y[Y_W-1:0];
  assign vga_colour = base_c;
  assign vga_plot   = (state == DRAW) && (sum_x < (X_W+1)'(SCREEN_W))
                      && (sum_y < (Y_W+1)'(SCREEN_H));
  assign req_ready  = (state == IDLE);
  assign busy       = (state == DRAW) || (state == DONE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_block_plotter.sv
// Scoreboard bench for block_plotter: stimulus queues expected pixels and done cycles,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_block_plotter;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_x = '0;
  logic [6:0] req_y = '0;
  logic [2:0] req_color = '0;
  logic       req_ready, vga_plot, busy, done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  logic       s_valid = 1'b0;
  logic [7:0] s_x = '0;
  logic [6:0] s_y = '0;
  logic [2:0] s_c = '0;
  logic       s_ready, s_plot, s_busy, s_done;
  logic [7:0] s_vx;
  logic [6:0] s_vy;
  logic [2:0] s_vc;

  always #5 clock = ~clock;

  block_plotter #(.SIZE(4)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_color(req_color), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .done(done));

  block_plotter #(.SIZE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(s_valid), .req_ready(s_ready),
    .req_x(s_x), .req_y(s_y), .req_color(s_c), .vga_x(s_vx), .vga_y(s_vy),
    .vga_colour(s_vc), .vga_plot(s_plot), .busy(s_busy), .done(s_done));

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  logic [17:0] pix_q[$];
  int done_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                              name, act, act, exp, exp, cyc);
    else n_pass++;
  endtask

  always @(negedge clock) begin : monitor
    logic [17:0] pe;
    int de;
    if (vga_plot) begin
      if (pix_q.size() == 0) chk("extra_plot", 32'(vga_plot), 32'd0);
      else begin
        pe = pix_q.pop_front();
        chk("pixel_xyc", {14'b0, vga_x, vga_y, vga_colour}, {14'b0, pe});
      end
    end
    if (done) begin
      if (done_q.size() == 0) chk("extra_done", 32'(done), 32'd0);
      else begin
        de = done_q.pop_front();
        chk("done_cycle", cyc, de);
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                      output int acc);
    int sx, sy;
    req_x = x; req_y = y; req_color = c; req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clock);
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
    else begin
      acc = cyc + 1;
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) begin
          sx = int'(x) + k;
          sy = int'(y) + r;
          if (sx < 160 && sy < 120) pix_q.push_back({8'(sx), 7'(sy), c});
        end
      done_q.push_back(acc + 16);
      @(negedge clock);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && !(req_ready && done_q.size() == 0); i++) @(negedge clock);
    chk("idle_timeout", done_q.size(), 32'd0);
    @(negedge clock);
  endtask

  int a1, a2;

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_vga_x", 32'(vga_x), 32'd0);
    chk("rst_vga_y", 32'(vga_y), 32'd0);
    chk("rst_colour", 32'(vga_colour), 32'd0);
    chk("rst_plot", 32'(vga_plot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_ready", 32'(req_ready), 32'd1);

    // Square fully on screen, with latency of done/ready.
    send(8'd78, 7'd54, 3'd7, a1);
    req_valid = 1'b0;
    repeat (16) @(negedge clock);
    chk("t1_ready_in_done", 32'(req_ready), 32'd0);
    chk("t1_busy_in_done", 32'(busy), 32'd1);
    @(negedge clock);
    chk("t1_ready_back", 32'(req_ready), 32'd1);
    chk("t1_busy_clear", 32'(busy), 32'd0);
    chk("t1_hold_x", 32'(vga_x), 32'd81);
    chk("t1_hold_y", 32'(vga_y), 32'd57);
    wait_idle();

    // Held valid, inputs disturbed mid-square, back-to-back accept.
    send(8'd78, 7'd54, 3'd7, a1);
    req_x = 8'd200; req_y = 7'd3; req_color = 3'd1;
    @(negedge clock);
    send(8'd10, 7'd20, 3'd2, a2);
    req_valid = 1'b0;
    chk("b2b_accept_gap", a2 - a1, 32'd18);
    wait_idle();

    // Bottom-right corner clipping.
    send(8'd158, 7'd118, 3'd2, a1);
    req_valid = 1'b0;
    wait_idle();

    // Fully off-screen via overflow.
    send(8'd254, 7'd126, 3'd1, a1);
    req_valid = 1'b0;
    wait_idle();

    // Reset after five pixels abandons the square.
    send(8'd40, 7'd30, 3'd4, a1);
    req_valid = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("mid_rst_plot", 32'(vga_plot), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_pending", pix_q.size(), 32'd11);
    pix_q.delete();
    done_q.delete();
    reset_n = 1'b1;
    @(negedge clock);
    send(8'd5, 7'd6, 3'd3, a1);
    req_valid = 1'b0;
    wait_idle();

    // SIZE=1 instance: single pixel then done.
    s_x = 8'd0; s_y = 7'd0; s_c = 3'd5; s_valid = 1'b1;
    chk("s1_ready", 32'(s_ready), 32'd1);
    @(negedge clock);
    s_valid = 1'b0;
    chk("s1_plot", 32'(s_plot), 32'd1);
    chk("s1_xy", {17'b0, s_vx, s_vy}, 32'd0);
    chk("s1_colour", 32'(s_vc), 32'd5);
    chk("s1_no_early_done", 32'(s_done), 32'd0);
    @(negedge clock);
    chk("s1_plot_off", 32'(s_plot), 32'd0);
    chk("s1_done", 32'(s_done), 32'd1);
    @(negedge clock);
    chk("s1_done_clear", 32'(s_done), 32'd0);
    chk("s1_ready_back", 32'(s_ready), 32'd1);

    chk("pixels_left", pix_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
